// File: rtl/mesh_rasterizer_if.sv
// mesh_rasterizer_if: pixel stream from the rasterizer to the framebuffer.
// The master drives coordinates, tag and valid; the slave drives ready.
interface mesh_rasterizer_if #(
    parameter int COORD_WIDTH = 32,
    parameter int TRI_AW      = 6
);
    logic signed [COORD_WIDTH-1:0] pix_x;
    logic signed [COORD_WIDTH-1:0] pix_y;
    logic [TRI_AW-1:0]             pix_tri;
    logic                          pix_valid;
    logic                          pix_ready;

    modport master (
        output pix_x, pix_y, pix_tri, pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_x, pix_y, pix_tri, pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/mesh_rasterizer.sv
// mesh_rasterizer: walks a triangle list through an external projector and
// scan filler, culls off-screen triangles and streams on-screen pixels.
module mesh_rasterizer #(
    parameter int  COORD_WIDTH = 32,
    parameter int  FRAC_BITS   = 16,
    parameter int  MAX_TRIS    = 64,
    parameter int  SCREEN_W    = 320,
    parameter int  SCREEN_H    = 180,
    localparam int TRI_AW      = $clog2(MAX_TRIS),
    localparam int VW          = 9 * COORD_WIDTH
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start,
    input  logic [TRI_AW:0]               tri_count,
    output logic [TRI_AW-1:0]             tri_addr,
    output logic                          tri_rd_en,
    input  logic [VW-1:0]                 tri_data,
    output logic                          proj_start,
    output logic [VW-1:0]                 proj_verts,
    input  logic [VW-1:0]                 proj_result,
    input  logic                          proj_valid,
    input  logic                          proj_done,
    output logic                          fill_start,
    output logic signed [COORD_WIDTH-1:0] fill_x0,
    output logic signed [COORD_WIDTH-1:0] fill_y0,
    output logic signed [COORD_WIDTH-1:0] fill_x1,
    output logic signed [COORD_WIDTH-1:0] fill_y1,
    output logic signed [COORD_WIDTH-1:0] fill_x2,
    output logic signed [COORD_WIDTH-1:0] fill_y2,
    output logic                          fill_oe,
    input  logic signed [COORD_WIDTH-1:0] fill_x,
    input  logic signed [COORD_WIDTH-1:0] fill_y,
    input  logic                          fill_drawing,
    input  logic                          fill_done,
    mesh_rasterizer_if.master             pix,
    output logic                          busy,
    output logic                          done,
    output logic [TRI_AW:0]               tris_drawn,
    output logic [TRI_AW:0]               tris_culled
);
    localparam int CW = COORD_WIDTH;

    typedef logic signed [CW-1:0] coord_t;

    localparam coord_t          ZERO = '0;
    localparam coord_t          SW   = coord_t'(SCREEN_W);
    localparam coord_t          SH   = coord_t'(SCREEN_H);
    localparam logic [TRI_AW:0] MAXC = (TRI_AW + 1)'(MAX_TRIS);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_MEM, PROJECT, CULL, DRAW, NEXT, FINISH
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [TRI_AW:0]   count_q;
    logic [TRI_AW-1:0] index;
    logic              cull;
    logic              in_bounds;
    logic              pix_valid_c;
    coord_t            nx0, ny0, nx1, ny1, nx2, ny2;
    logic              unused_z;

    function automatic coord_t to_pix(input coord_t v);
        return v >>> FRAC_BITS;
    endfunction

    assign nx0 = to_pix(proj_result[0*CW +: CW]);
    assign ny0 = to_pix(proj_result[1*CW +: CW]);
    assign nx1 = to_pix(proj_result[3*CW +: CW]);
    assign ny1 = to_pix(proj_result[4*CW +: CW]);
    assign nx2 = to_pix(proj_result[6*CW +: CW]);
    assign ny2 = to_pix(proj_result[7*CW +: CW]);

    // Depth is not used by the 2D filler.
    assign unused_z = ^{proj_result[2*CW +: CW],
                        proj_result[5*CW +: CW],
                        proj_result[8*CW +: CW]};

    assign cull =
        ((fill_x0 <  ZERO) && (fill_x1 <  ZERO) && (fill_x2 <  ZERO)) ||
        ((fill_x0 >= SW)   && (fill_x1 >= SW)   && (fill_x2 >= SW))   ||
        ((fill_y0 <  ZERO) && (fill_y1 <  ZERO) && (fill_y2 <  ZERO)) ||
        ((fill_y0 >= SH)   && (fill_y1 >= SH)   && (fill_y2 >= SH));

    assign in_bounds = (fill_x >= ZERO) && (fill_x < SW) &&
                       (fill_y >= ZERO) && (fill_y < SH);

    assign tri_addr      = index;
    assign busy          = (state != IDLE) && (state != FINISH);
    assign done          = (state == FINISH);
    assign pix.pix_x     = fill_x;
    assign pix.pix_y     = fill_y;
    assign pix.pix_tri   = index;
    assign pix.pix_valid = pix_valid_c;

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nx;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nx    = state;
        tri_rd_en   = 1'b0;
        fill_start  = 1'b0;
        fill_oe     = 1'b0;
        pix_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (tri_count == '0) ? FINISH : FETCH;
            end
            FETCH: begin
                tri_rd_en = 1'b1;
                state_nx  = WAIT_MEM;
            end
            WAIT_MEM: state_nx = PROJECT;
            PROJECT: begin
                if (proj_done) state_nx = proj_valid ? CULL : NEXT;
            end
            CULL: begin
                if (cull) begin
                    state_nx = NEXT;
                end else begin
                    fill_start = 1'b1;
                    state_nx   = DRAW;
                end
            end
            DRAW: begin
                fill_oe     = pix.pix_ready;
                pix_valid_c = fill_drawing && in_bounds;
                if (fill_done) state_nx = NEXT;
            end
            NEXT: begin
                if (({1'b0, index} + 1'b1) == count_q) state_nx = FINISH;
                else                                   state_nx = FETCH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame bookkeeping, vertex capture and converted coordinates.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q     <= '0;
            index       <= '0;
            tris_drawn  <= '0;
            tris_culled <= '0;
            proj_verts  <= '0;
            proj_start  <= 1'b0;
            fill_x0     <= '0;
            fill_y0     <= '0;
            fill_x1     <= '0;
            fill_y1     <= '0;
            fill_x2     <= '0;
            fill_y2     <= '0;
        end else begin
            proj_start <= (state == WAIT_MEM);
            case (state)
                IDLE: begin
                    if (start) begin
                        count_q     <= (tri_count > MAXC) ? MAXC : tri_count;
                        index       <= '0;
                        tris_drawn  <= '0;
                        tris_culled <= '0;
                    end
                end
                WAIT_MEM: proj_verts <= tri_data;
                PROJECT: begin
                    if (proj_done) begin
                        if (!proj_valid) begin
                            tris_culled <= tris_culled + 1'b1;
                        end else begin
                            fill_x0 <= nx0;
                            fill_y0 <= ny0;
                            fill_x1 <= nx1;
                            fill_y1 <= ny1;
                            fill_x2 <= nx2;
                            fill_y2 <= ny2;
                        end
                    end
                end
                CULL: begin
                    if (cull) tris_culled <= tris_culled + 1'b1;
                end
                DRAW: begin
                    if (fill_done) tris_drawn <= tris_drawn + 1'b1;
                end
                NEXT:    index <= index + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
